// File: rtl/aes_round_seq.sv
// Iterative AES-128 sequencer: round-robin picks a requester, then one external round per clock.
// Latency: out_valid rises NR clocks after the accepting edge; NR+2 cycles minimum per block.
// Backpressure: out_ready low holds DONE with stable outputs; requesters get no ready until IDLE.
module aes_round_seq #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [128*(NR+1)-1:0] w,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [127:0]          req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [127:0]          req1_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  out_id,
    output logic                  busy,
    output logic [127:0]          ru_state,
    output logic [127:0]          ru_key,
    output logic [1:0]            ru_mode,
    input  logic [127:0]          ru_result
);

    localparam logic [1:0]    MODE_INIT  = 2'd0;
    localparam logic [1:0]    MODE_FULL  = 2'd1;
    localparam logic [1:0]    MODE_FINAL = 2'd2;
    localparam logic [RW-1:0] RND_LAST   = RW'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [127:0]  state_reg;
    logic [RW-1:0] rnd;
    logic          id_reg;
    logic          last_grant;
    logic          grant;
    logic          idle;
    logic          accept;

    assign idle   = (state == IDLE);
    assign accept = idle && (req0_valid || req1_valid);

    // Contention goes to whoever did not win last time; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst_n so nothing is acknowledged while reset is held.
    assign req0_ready = rst_n && idle && req0_valid && !grant;
    assign req1_ready = rst_n && idle && req1_valid &&  grant;

    assign out_data = state_reg;
    assign out_id   = id_reg;

    always_comb begin
        ru_state = state_reg;
        ru_mode  = MODE_INIT;
        if (idle) begin
            ru_state = 128'd0;
            if (req0_valid || req1_valid) begin
                ru_state = grant ? req1_data : req0_data;
            end
        end else if (state == ROUND) begin
            ru_mode = (rnd == RND_LAST) ? MODE_FINAL : MODE_FULL;
        end
    end

    always_comb begin
        ru_key = w[127:0];
        for (int r = 1; r <= NR; r++) begin
            if (!idle && rnd == RW'(r)) begin
                ru_key = w[128*r +: 128];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            state_reg  <= 128'd0;
            rnd        <= '0;
            id_reg     <= 1'b0;
            last_grant <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_reg  <= ru_result;
                        id_reg     <= grant;
                        last_grant <= grant;
                        rnd        <= RW'(1);
                        busy       <= 1'b1;
                        state      <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= ru_result;
                    if (rnd == RND_LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd + RW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        rnd       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq with a reference AES round unit and key expansion.
module tb_aes_round_seq;

    localparam int NR = 10;
    localparam int RW = 4;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [128*(NR+1)-1:0] w;
    logic                  req0_valid, req0_ready;
    logic [127:0]          req0_data;
    logic                  req1_valid, req1_ready;
    logic [127:0]          req1_data;
    logic                  out_valid, out_ready;
    logic [127:0]          out_data;
    logic                  out_id;
    logic                  busy;
    logic [127:0]          ru_state, ru_key, ru_result;
    logic [1:0]            ru_mode;

    int ncmp = 0;
    int nerr = 0;
    logic [128*(NR+1)-1:0] w1, w2;

    always #5 clk = ~clk;

    aes_round_seq #(.NR(NR), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .w(w),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .busy(busy), .ru_state(ru_state), .ru_key(ru_key), .ru_mode(ru_mode),
        .ru_result(ru_result)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] bse;
        logic [7:0] e;
        r = 8'h01;
        bse = x;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, bse);
            bse = gmul(bse, bse);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic [1:0] mode);
        logic [7:0]   t [16];
        logic [7:0]   u [16];
        logic [127:0] v;
        logic [7:0]   a0, a1, a2, a3;
        if (mode == 2'd0) return s ^ k;
        for (int i = 0; i < 16; i++) t[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                u[r+4*c] = t[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
            if (mode == 2'd1) begin
                u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = u[i];
        return v ^ k;
    endfunction

    function automatic logic [128*(NR+1)-1:0] expand(input logic [127:0] key);
        logic [31:0] ww [4*(NR+1)];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [128*(NR+1)-1:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) ww[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            tmp = ww[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            ww[i] = ww[i-4] ^ tmp;
        end
        for (int i = 0; i < 4*(NR+1); i++) res[128*(i/4) + 127 - 32*(i%4) -: 32] = ww[i];
        return res;
    endfunction

    always_comb ru_result = aes_round(ru_state, ru_key, ru_mode);

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered with requester inputs already set in IDLE; returns one cycle after the handshake.
    task automatic do_block(input string tag, input logic id, input logic [127:0] pt,
                            input logic [127:0] ct, input int hold);
        int         n;
        int         bad_key;
        int         bad_rdy;
        logic [19:0] modes;
        #1;
        chk({tag, ".grant"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        chk({tag, ".init"}, {ru_mode, ru_state, ru_key}, {2'd0, pt, w[127:0]});
        tick;
        n = 0; bad_key = 0; bad_rdy = 0; modes = '0;
        while (n < 40 && !out_valid) begin
            if (n < 10) begin
                modes[2*n +: 2] = ru_mode;
                if (ru_key !== w[128*(n+1) +: 128]) bad_key++;
            end
            if (req0_ready || req1_ready || !busy) bad_rdy++;
            tick;
            n++;
        end
        chk({tag, ".latency"}, n, 10);
        chk({tag, ".modes"}, modes, {2'd2, {9{2'd1}}});
        chk({tag, ".keys"}, bad_key, 0);
        chk({tag, ".round_flags"}, bad_rdy, 0);
        chk({tag, ".out"}, {out_id, out_data}, {id, ct});
        for (int h = 0; h < hold; h++) begin
            tick;
            chk({tag, ".hold"}, {out_valid, busy, req0_ready, req1_ready, out_id, out_data},
                {1'b1, 1'b1, 1'b0, 1'b0, id, ct});
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, ".idle"}, {out_valid, busy}, 2'b00);
    endtask

    initial begin
        w1 = expand(K1);
        w2 = expand(K2);
        rst_n = 1'b0;
        w = w1;
        out_ready = 1'b0;
        req0_valid = 1'b1;
        req0_data = P1;
        req1_valid = 1'b0;
        req1_data = PB;
        #3;
        chk("reset_outputs", {req0_ready, req1_ready, out_valid, busy, out_id, out_data}, '0);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick;

        // FIPS-197 C.1 through requester 0
        w = w1; req0_data = P1; req0_valid = 1'b1;
        do_block("c1", 1'b0, P1, CT1, 0);
        req0_valid = 1'b0;

        // FIPS-197 B through requester 1
        w = w2; req1_data = PB; req1_valid = 1'b1;
        do_block("fipsb", 1'b1, PB, CTB, 0);
        req1_valid = 1'b0;

        // Output backpressure, then immediate re-acceptance
        w = w1; req0_data = P1; req0_valid = 1'b1;
        do_block("bp", 1'b0, P1, CT1, 5);
        do_block("bp_next", 1'b0, P1, CT1, 0);
        req0_valid = 1'b0;

        // Reset restores req0 priority; both continuously valid must alternate
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req0_data = P1; req1_data = PB;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = (i % 2 == 1) ? w2 : w1;
            do_block($sformatf("rr%0d", i), (i % 2 == 1), (i % 2 == 1) ? PB : P1,
                     (i % 2 == 1) ? CTB : CT1, 0);
        end
        req1_valid = 1'b0;

        // Asynchronous reset in the middle of round 5 discards the block
        w = w1; req0_data = P1; req0_valid = 1'b1;
        tick;
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {req0_ready, req1_ready, out_valid, busy, out_id, out_data}, '0);
        req1_data = 128'hdeadbeef_00000000_12345678_9abcdef0;
        req1_valid = 1'b1;
        #1 rst_n = 1'b1;
        req1_data = PB;
        do_block("after_rst", 1'b0, P1, CT1, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
